// File: rtl/lru_victim_sel_pkg.sv
`default_nettype none
//==============================================================================
// Package  : lru_pkg
// Brief    : Shared types for the age-counter LRU victim selector.
// Revision : 1.0
//==============================================================================
package lru_pkg;

  // Pending-slot fields are sized from these; module WIDTH/SETW must match.
  localparam int c_LRU_WIDTH = 3;
  localparam int c_LRU_SETW  = 6;

  typedef logic [c_LRU_WIDTH-1:0] lru_age_t;

  typedef struct packed {
    logic                  valid;
    logic [c_LRU_SETW-1:0] set;
    lru_age_t              way;
  } lru_pend_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_OFFER = 2'd2
  } lru_vsel_state_t;

endpackage
`default_nettype wire

// File: rtl/lru_victim_sel_oldest_find.sv
`default_nettype none
//==============================================================================
// Module   : lru_oldest_find
// Brief    : Combinational max-age finder with exclude mask; ties -> lowest way.
// Revision : 1.0
//==============================================================================
module lru_oldest_find
  import lru_pkg::*;
#(
  parameter int WIDTH = c_LRU_WIDTH
) (
  input  logic [(1<<WIDTH)*WIDTH-1:0] ages,
  input  logic [(1<<WIDTH)-1:0]       excl,
  output logic [WIDTH-1:0]            oldWay,
  output logic                        anyValid
);

  localparam int c_WAYS = 1 << WIDTH;

  logic             w_found;
  logic [WIDTH-1:0] w_bestAge;
  logic [WIDTH-1:0] w_bestWay;

  // Strict '>' keeps the first (lowest-index) way among equal ages.
  always_comb begin
    w_found   = 1'b0;
    w_bestAge = '0;
    w_bestWay = '0;
    for (int k = 0; k < c_WAYS; k++) begin
      if (!excl[k] && (!w_found || (ages[k*WIDTH +: WIDTH] > w_bestAge))) begin
        w_found   = 1'b1;
        w_bestAge = ages[k*WIDTH +: WIDTH];
        w_bestWay = WIDTH'(k);
      end
    end
  end

  assign oldWay   = w_bestWay;
  assign anyValid = w_found;

endmodule
`default_nettype wire

// File: rtl/lru_victim_sel.sv
`default_nettype none
//==============================================================================
// Module   : lru_victim_sel
// Brief    : Picks LRU victim ways for misses, tracks pending refills and
//            requests MRU promotion on refill completion.
//            Optional stats counters: define LRU_VICTIM_STATS_EN.
// Revision : 1.0
//==============================================================================
module lru_victim_sel
  import lru_pkg::*;
#(
  parameter int WIDTH = c_LRU_WIDTH,
  parameter int SETW  = c_LRU_SETW,
  parameter int NPEND = 4,
  parameter int PIDW  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SETW-1:0]             req_set,
  input  logic [(1<<WIDTH)*WIDTH-1:0] req_lru,
  output logic                        vic_valid,
  input  logic                        vic_ready,
  output logic [SETW-1:0]             vic_set,
  output logic [WIDTH-1:0]            vic_way,
  output logic [PIDW-1:0]             vic_id,
  input  logic                        fill_done,
  input  logic [PIDW-1:0]             fill_id,
  output logic                        upd_en,
  output logic [SETW-1:0]             upd_set,
  output logic [WIDTH-1:0]            upd_way
`ifdef LRU_VICTIM_STATS_EN
  ,
  output logic [31:0]                 stat_picks,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int c_WAYS = 1 << WIDTH;

  lru_vsel_state_t             r_state;
  lru_vsel_state_t             w_nextState;
  logic                        r_live;
  logic [SETW-1:0]             r_reqSet;
  logic [c_WAYS*WIDTH-1:0]     r_reqLru;
  lru_pend_t                   r_pend [NPEND];
  logic [SETW-1:0]             r_vicSet;
  logic [WIDTH-1:0]            r_vicWay;
  logic [PIDW-1:0]             r_vicId;
  logic                        r_updEn;
  logic [SETW-1:0]             r_updSet;
  logic [WIDTH-1:0]            r_updWay;

  logic                        w_anyFree;
  logic [PIDW-1:0]             w_freeId;
  logic [c_WAYS-1:0]           w_excl;
  logic [WIDTH-1:0]            w_oldWay;
  logic                        w_oldAny;
  logic                        w_fillHit;
  logic [SETW-1:0]             w_fillSet;
  logic [WIDTH-1:0]            w_fillWay;
  logic                        w_reqReady;
  logic                        w_vicValid;
  logic                        w_alloc;
  logic                        w_reqFire;
  logic                        w_vicFire;

  // All slot decisions look at the registered table only, so a slot being
  // retired this cycle still excludes its way and is never re-allocated yet.
  always_comb begin
    w_anyFree = 1'b0;
    w_freeId  = '0;
    for (int i = NPEND - 1; i >= 0; i--) begin
      if (!r_pend[i].valid) begin
        w_anyFree = 1'b1;
        w_freeId  = PIDW'(i);
      end
    end
  end

  always_comb begin
    w_excl = '0;
    for (int i = 0; i < NPEND; i++) begin
      if (r_pend[i].valid && (r_pend[i].set == r_reqSet)) begin
        w_excl[r_pend[i].way] = 1'b1;
      end
    end
  end

  always_comb begin
    w_fillHit = 1'b0;
    w_fillSet = '0;
    w_fillWay = '0;
    for (int i = 0; i < NPEND; i++) begin
      if (fill_done && (fill_id == PIDW'(i)) && r_pend[i].valid) begin
        w_fillHit = 1'b1;
        w_fillSet = r_pend[i].set;
        w_fillWay = r_pend[i].way;
      end
    end
  end

  lru_oldest_find #(
    .WIDTH (WIDTH)
  ) u_oldestFind (
    .ages     (r_reqLru),
    .excl     (w_excl),
    .oldWay   (w_oldWay),
    .anyValid (w_oldAny)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_reqFire) w_nextState = ST_PICK;
      ST_PICK:  if (w_oldAny) w_nextState = ST_OFFER;
      ST_OFFER: if (w_vicFire) w_nextState = w_reqFire ? ST_PICK : ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Accepting in OFFER lets a new miss overlap the outgoing victim handshake.
  always_comb begin
    w_reqReady = 1'b0;
    w_vicValid = 1'b0;
    w_alloc    = 1'b0;
    case (r_state)
      ST_IDLE:  w_reqReady = r_live && w_anyFree;
      ST_PICK:  w_alloc = w_oldAny;
      ST_OFFER: begin
        w_vicValid = 1'b1;
        w_reqReady = vic_ready && w_anyFree;
      end
      default: ;
    endcase
  end

  assign w_reqFire = req_valid && w_reqReady;
  assign w_vicFire = w_vicValid && vic_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reqSet <= '0;
      r_reqLru <= '0;
      r_vicSet <= '0;
      r_vicWay <= '0;
      r_vicId  <= '0;
      for (int i = 0; i < NPEND; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      if (w_reqFire) begin
        r_reqSet <= req_set;
        r_reqLru <= req_lru;
      end
      if (w_alloc) begin
        r_vicSet <= r_reqSet;
        r_vicWay <= w_oldWay;
        r_vicId  <= w_freeId;
      end
      for (int i = 0; i < NPEND; i++) begin
        if (w_fillHit && (fill_id == PIDW'(i))) begin
          r_pend[i].valid <= 1'b0;
        end
        if (w_alloc && (w_freeId == PIDW'(i))) begin
          r_pend[i] <= '{valid: 1'b1, set: r_reqSet, way: w_oldWay};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_updEn  <= 1'b0;
      r_updSet <= '0;
      r_updWay <= '0;
    end else begin
      r_updEn <= w_fillHit;
      if (w_fillHit) begin
        r_updSet <= w_fillSet;
        r_updWay <= w_fillWay;
      end
    end
  end

  assign req_ready = w_reqReady;
  assign vic_valid = w_vicValid;
  assign vic_set   = r_vicSet;
  assign vic_way   = r_vicWay;
  assign vic_id    = r_vicId;
  assign upd_en    = r_updEn;
  assign upd_set   = r_updSet;
  assign upd_way   = r_updWay;

`ifdef LRU_VICTIM_STATS_EN
  logic [31:0] r_statPicks;
  logic [31:0] r_statStall;
  logic        w_stallCyc;

  assign w_stallCyc = ((r_state == ST_PICK) && !w_oldAny) ||
                      ((r_state == ST_IDLE) && req_valid && !w_anyFree);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statPicks <= '0;
      r_statStall <= '0;
    end else begin
      if (w_vicFire && (r_statPicks != '1)) r_statPicks <= r_statPicks + 32'd1;
      if (w_stallCyc && (r_statStall != '1)) r_statStall <= r_statStall + 32'd1;
    end
  end

  assign stat_picks = r_statPicks;
  assign stat_stall = r_statStall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lru_victim_sel.sv
`default_nettype none
//==============================================================================
// Module   : tb_lru_victim_sel
// Brief    : Directed, table-driven self-checking bench for lru_victim_sel.
// Revision : 1.0
//==============================================================================
module tb_lru_victim_sel;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_set;
  logic [23:0] req_lru;
  logic        vic_valid;
  logic        vic_ready;
  logic [5:0]  vic_set;
  logic [2:0]  vic_way;
  logic [1:0]  vic_id;
  logic        fill_done;
  logic [1:0]  fill_id;
  logic        upd_en;
  logic [5:0]  upd_set;
  logic [2:0]  upd_way;
`ifdef LRU_VICTIM_STATS_EN
  logic [31:0] statPicks;
  logic [31:0] statStall;
`endif

  int total = 0;
  int bad   = 0;

  lru_victim_sel u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_set   (req_set),
    .req_lru   (req_lru),
    .vic_valid (vic_valid),
    .vic_ready (vic_ready),
    .vic_set   (vic_set),
    .vic_way   (vic_way),
    .vic_id    (vic_id),
    .fill_done (fill_done),
    .fill_id   (fill_id),
    .upd_en    (upd_en),
    .upd_set   (upd_set),
    .upd_way   (upd_way)
`ifdef LRU_VICTIM_STATS_EN
    ,
    .stat_picks (statPicks),
    .stat_stall (statStall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  set;
    logic [23:0] lru;
    logic        fillEn;
    logic [1:0]  fillId;
    logic [2:0]  expWay;
    logic [1:0]  expId;
    logic        expUpd;
    logic [5:0]  expUpdSet;
    logic [2:0]  expUpdWay;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [23:0] mkAges(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7);
    logic [23:0] r;
    r[2:0]   = 3'(a0);
    r[5:3]   = 3'(a1);
    r[8:6]   = 3'(a2);
    r[11:9]  = 3'(a3);
    r[14:12] = 3'(a4);
    r[17:15] = 3'(a5);
    r[20:18] = 3'(a6);
    r[23:21] = 3'(a7);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the victim handshake.
  task automatic doReq(input vec_t v, input int idx);
    int n;
    req_valid = 1'b1;
    req_set   = v.set;
    req_lru   = v.lru;
    n = 0;
    while ((req_ready !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_readyWait", idx), 32'(n < 20), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_pickNoValid", idx), 32'(vic_valid), 32'd0);
    chk($sformatf("v%0d_pickNoUpd", idx), 32'(upd_en), 32'd0);
    req_valid = 1'b0;
    if (v.fillEn) begin
      fill_done = 1'b1;
      fill_id   = v.fillId;
    end
    @(negedge clk);
    fill_done = 1'b0;
    chk($sformatf("v%0d_vicValid", idx), 32'(vic_valid), 32'd1);
    chk($sformatf("v%0d_vicSet", idx), 32'(vic_set), 32'(v.set));
    chk($sformatf("v%0d_vicWay", idx), 32'(vic_way), 32'(v.expWay));
    chk($sformatf("v%0d_vicId", idx), 32'(vic_id), 32'(v.expId));
    chk($sformatf("v%0d_updEn", idx), 32'(upd_en), 32'(v.expUpd));
    if (v.expUpd) begin
      chk($sformatf("v%0d_updSet", idx), 32'(upd_set), 32'(v.expUpdSet));
      chk($sformatf("v%0d_updWay", idx), 32'(upd_way), 32'(v.expUpdWay));
    end
    @(negedge clk);
    chk($sformatf("v%0d_vicDone", idx), 32'(vic_valid), 32'd0);
    chk($sformatf("v%0d_updOneCyc", idx), 32'(upd_en), 32'd0);
  endtask

  logic [23:0] ageA;
  logic [23:0] ageB;
  logic [23:0] ageC;
  logic [23:0] ageZ;

  initial begin
    int n;
    ageA = mkAges(3, 7, 0, 1, 2, 4, 5, 6);
    ageB = mkAges(2, 7, 0, 1, 3, 5, 4, 6);
    ageC = mkAges(4, 2, 6, 6, 1, 6, 0, 3);
    ageZ = mkAges(0, 0, 0, 0, 0, 0, 0, 0);

    //             set  lru   fill  id    way   id    upd   uSet  uWay
    vecs[0] = '{6'd5, ageA, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 6'd0, 3'd0};
    vecs[1] = '{6'd5, ageA, 1'b0, 2'd0, 3'd7, 2'd1, 1'b0, 6'd0, 3'd0};
    vecs[2] = '{6'd6, ageA, 1'b0, 2'd0, 3'd1, 2'd2, 1'b0, 6'd0, 3'd0};
    vecs[3] = '{6'd5, ageA, 1'b0, 2'd0, 3'd6, 2'd3, 1'b0, 6'd0, 3'd0};
    vecs[4] = '{6'd5, ageB, 1'b1, 2'd0, 3'd5, 2'd2, 1'b1, 6'd5, 3'd1};
    vecs[5] = '{6'd5, ageA, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 6'd0, 3'd0};
    vecs[6] = '{6'd5, ageA, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 6'd0, 3'd0};
    vecs[7] = '{6'd9, ageZ, 1'b0, 2'd0, 3'd0, 2'd1, 1'b0, 6'd0, 3'd0};
    vecs[8] = '{6'd5, ageC, 1'b0, 2'd0, 3'd2, 2'd2, 1'b0, 6'd0, 3'd0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_set   = '0;
    req_lru   = '0;
    vic_ready = 1'b1;
    fill_done = 1'b0;
    fill_id   = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_reqReady", 32'(req_ready), 32'd0);
    chk("rst_vicValid", 32'(vic_valid), 32'd0);
    chk("rst_updEn", 32'(upd_en), 32'd0);
    chk("rst_vicSet", 32'(vic_set), 32'd0);
    chk("rst_vicWay", 32'(vic_way), 32'd0);
    chk("rst_vicId", 32'(vic_id), 32'd0);
    chk("rst_updSet", 32'(upd_set), 32'd0);
    chk("rst_updWay", 32'(upd_way), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) doReq(vecs[i], i);

    // All four slots pending: request must wait until one retires.
    req_valid = 1'b1;
    req_set   = 6'd5;
    req_lru   = ageB;
    #1;
    chk("full_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("full_ready1", 32'(req_ready), 32'd0);
    fill_done = 1'b1;
    fill_id   = 2'd2;
    @(negedge clk);
    fill_done = 1'b0;
    chk("free_ready", 32'(req_ready), 32'd1);
    chk("free_updEn", 32'(upd_en), 32'd1);
    chk("free_updSet", 32'(upd_set), 32'd6);
    chk("free_updWay", 32'(upd_way), 32'd1);

    doReq(vecs[4], 4);

    fill_done = 1'b1;
    fill_id   = 2'd3;
    @(negedge clk);
    fill_done = 1'b0;
    chk("ret3_updEn", 32'(upd_en), 32'd1);
    chk("ret3_updSet", 32'(upd_set), 32'd5);
    chk("ret3_updWay", 32'(upd_way), 32'd6);
    fill_done = 1'b1;
    fill_id   = 2'd3;
    @(negedge clk);
    fill_done = 1'b0;
    chk("ghost3_updEn", 32'(upd_en), 32'd0);

    doReq(vecs[5], 5);

    // Hold a victim in OFFER, then reset underneath it.
    vic_ready = 1'b0;
    req_valid = 1'b1;
    req_set   = 6'd5;
    req_lru   = ageA;
    n = 0;
    while ((req_ready !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk("hold_readyWait", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_vicValid", 32'(vic_valid), 32'd1);
    chk("hold_vicWay", 32'(vic_way), 32'd6);
    chk("hold_vicId", 32'(vic_id), 32'd3);
    @(negedge clk);
    chk("hold_vicValid2", 32'(vic_valid), 32'd1);
    chk("hold_vicWay2", 32'(vic_way), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vicValid", 32'(vic_valid), 32'd0);
    chk("midrst_reqReady", 32'(req_ready), 32'd0);
    chk("midrst_updEn", 32'(upd_en), 32'd0);
    chk("midrst_vicWay", 32'(vic_way), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    vic_ready = 1'b1;
    fill_done = 1'b1;
    fill_id   = 2'd1;
    @(negedge clk);
    fill_done = 1'b0;
    chk("postrst_noUpd", 32'(upd_en), 32'd0);

    for (int i = 6; i < 9; i++) doReq(vecs[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lru_victim_sel.md
Name: lru_victim_sel

Overview:
- Replacement-side reader of the per-set age-counter LRU state.
- The age-counter updater writes ages: 0 = MRU, WAYS-1 = LRU. This block reads them and chooses a victim way for each cache miss.
- Tracks outstanding refills so a way being filled is never chosen twice.
- On refill completion, requests promotion of the filled way to MRU through the existing update path.
- Sits between the miss queue and the tag/LRU array wrapper.

Parameters:
- WIDTH, 3, age/way-index width; WAYS = 1<<WIDTH (localparam).
- SETW, 6, set-index width.
- NPEND, 4, outstanding-fill slots; legal range 1..WAYS-1.
- PIDW, 2, slot-id width; 2^PIDW >= NPEND.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  miss request
- req_ready  out  1  request accepted when valid&ready
- req_set  in  SETW  set index
- req_lru  in  WAYS*WIDTH  ages of the set's ways; way k at bits [k*WIDTH +: WIDTH]; held stable by the source until the matching vic handshake
- vic_valid  out  1  victim offered
- vic_ready  in  1  consumer takes victim
- vic_set  out  SETW  set of victim
- vic_way  out  WIDTH  victim way index
- vic_id  out  PIDW  pending slot allocated
- fill_done  in  1  refill finished
- fill_id  in  PIDW  slot being retired
- upd_en  out  1  one-cycle LRU promotion request
- upd_set  out  SETW  set to promote
- upd_way  out  WIDTH  way to promote to age 0

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE; all pending slots invalid.
  - req_ready=0, vic_valid=0, upd_en=0; vic_set/vic_way/vic_id/upd_set/upd_way = 0.
- FSM states IDLE, PICK, OFFER.
- IDLE:
  - req_ready = 1 iff at least one pending slot is free.
  - On handshake: latch req_set and req_lru, go to PICK.
- PICK (one cycle):
  - Exclude mask = ways held by valid pending slots whose set equals the latched set.
  - Exclusion uses the registered table; a slot freed in this same cycle still excludes.
  - Victim = non-excluded way with the maximum age; ties go to the lowest index.
  - If every way is excluded: stay in PICK and re-evaluate each cycle.
  - Otherwise: allocate the lowest free slot, register set/way/id, go to OFFER.
- OFFER:
  - vic_valid = 1 with outputs stable until vic_ready.
  - On handshake go to IDLE; req_ready can assert in the same cycle as that handshake.
- Latency: request handshake at cycle N gives vic_valid at N+2 (minimum).
- Slot allocation is visible for exclusion from the next PICK on.
- fill_done, valid slot:
  - Frees fill_id at the clock edge.
  - Next cycle: upd_en=1 for exactly one cycle, with upd_set/upd_way = that slot's contents.
  - Promotion does not stall and is not back-pressured.
- fill_done to an invalid slot: ignored, no upd_en.
- fill_done and allocation in the same cycle: allowed. Allocation never takes a slot that is being freed in that cycle (lowest free slot from the registered table).
- Reset mid-operation: pending fills are discarded and no upd_en is emitted; the requester must reissue.

Optional Feature:
- Macro: LRU_VICTIM_STATS_EN.
- Defined:
  - Adds outputs stat_picks[31:0] and stat_stall[31:0].
  - stat_picks increments on each vic handshake.
  - stat_stall increments on each cycle spent in PICK with all ways excluded, or in IDLE with req_valid=1 and no free slot.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package lru_pkg:
  - lru_age_t (logic [WIDTH-1:0]).
  - Pending-slot struct {valid, set, way}.
  - FSM enum lru_vsel_state_t.
- Sub-module lru_oldest_find:
  - Combinational maximum-age finder over WAYS entries with an exclude mask.
  - Outputs way index and any_valid.
  - Instantiated once in PICK.

Test Plan:
- WIDTH=3; set 5; ages way0..7 = {3,7,0,1,2,4,5,6}; vic_ready=1 -> vic_valid at N+2, vic_way=1, vic_set=5, vic_id=0.
- Without retiring slot 0, issue the same set/ages again -> vic_way=7 (age 6), vic_id=1. Then the same request for set 6 -> vic_way=1, vic_id=2 (no cross-set exclusion).
- Fill NPEND=4 slots, then req_valid=1 -> req_ready=0. Pulse fill_done id=2 -> req_ready=1 the cycle after.
- Ages with ways 1,7,6 pending in set 5 (NPEND=4, slots filled) plus a request for set 5 -> vic_way=5 (age 5). Same-cycle fill_done id=0 -> upd_en next cycle with upd_set=5, upd_way=1.
- fill_done id=3 while slot 3 is invalid -> no upd_en, table unchanged.
- Assert rst_n=0 while in OFFER -> vic_valid drops immediately, all slots invalid, and the next request gets vic_id=0.
